fifo_pkt_reader: RTL and testbench

FIFO_PKT_READER -- requirements
Module: fifo_pkt_reader

---
 rtl/fifo_pkt_reader_pkg.sv | 14 +
 rtl/fifo_pkt_reader_if.sv | 38 +++
 rtl/fifo_pkt_reader.sv | 109 ++++++++++
 tb/tb_fifo_pkt_reader.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/fifo_pkt_reader_pkg.sv
// Shared defines for the packet reader: default bus widths and FSM state encoding.
// Imported by the interface and the reader so that both agree on widths and states.
package fifo_pkt_reader_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 64;
    localparam int unsigned DEFAULT_CTRL_WIDTH = DEFAULT_DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StHdr  = 2'd1,
        StBody = 2'd2
    } state_e;

endpackage

// File: rtl/fifo_pkt_reader_if.sv
// Upstream fall-through FIFO head/pop signals plus the downstream word bus.
// The master modport is the reader; the slave modport is the surrounding FIFO/sink.
interface fifo_pkt_reader_if
    import fifo_pkt_reader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned CTRL_WIDTH = DEFAULT_CTRL_WIDTH
) ();

    logic [CTRL_WIDTH+DATA_WIDTH-1:0] fifo_dout;
    logic                             fifo_empty;
    logic                             fifo_rd_en;
    logic [DATA_WIDTH-1:0]            out_data;
    logic [CTRL_WIDTH-1:0]            out_ctrl;
    logic                             out_wr;
    logic                             out_rdy;

    modport master (
        input  fifo_dout,
        input  fifo_empty,
        output fifo_rd_en,
        output out_data,
        output out_ctrl,
        output out_wr,
        input  out_rdy
    );

    modport slave (
        output fifo_dout,
        output fifo_empty,
        input  fifo_rd_en,
        input  out_data,
        input  out_ctrl,
        input  out_wr,
        output out_rdy
    );

endinterface

// File: rtl/fifo_pkt_reader.sv
// Pops words from a fall-through FIFO and forwards complete packets downstream,
// discarding orphan body words seen while idle; counts packets and drops.
module fifo_pkt_reader
    import fifo_pkt_reader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned CTRL_WIDTH = DATA_WIDTH / 8
) (
    input  logic                clk,
    input  logic                reset,
    fifo_pkt_reader_if.master   bus,
    input  logic                enable,
    output logic [31:0]         pkt_count,
    output logic [31:0]         drop_count
);

    state_e state_q, state_d;

    logic [DATA_WIDTH-1:0] out_data_q;
    logic [CTRL_WIDTH-1:0] out_ctrl_q;
    logic                  out_wr_q;
    logic [31:0]           pkt_count_q;
    logic [31:0]           drop_count_q;

    logic [CTRL_WIDTH-1:0] head_ctrl;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  head_is_ctrl;
    logic                  pop;
    logic                  fwd;
    logic                  drop;
    logic                  pkt_done;

    assign head_ctrl    = bus.fifo_dout[CTRL_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
    assign head_data    = bus.fifo_dout[DATA_WIDTH-1:0];
    assign head_is_ctrl = |head_ctrl;

    always_comb begin
        state_d  = state_q;
        fwd      = 1'b0;
        drop     = 1'b0;
        pkt_done = 1'b0;
        // enable only gates the start of a packet; an open packet always drains
        pop = !reset && !bus.fifo_empty && bus.out_rdy && ((state_q != StIdle) || enable);
        if (pop) begin
            unique case (state_q)
                StIdle: begin
                    if (head_is_ctrl) begin
                        fwd     = 1'b1;
                        state_d = StHdr;
                    end else begin
                        drop = 1'b1;
                    end
                end
                StHdr: begin
                    fwd = 1'b1;
                    if (!head_is_ctrl) begin
                        state_d = StBody;
                    end
                end
                StBody: begin
                    fwd = 1'b1;
                    if (head_is_ctrl) begin
                        pkt_done = 1'b1;
                        state_d  = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            out_wr_q     <= 1'b0;
            out_data_q   <= '0;
            out_ctrl_q   <= '0;
            pkt_count_q  <= '0;
            drop_count_q <= '0;
        end else begin
            state_q  <= state_d;
            out_wr_q <= fwd;
            if (fwd) begin
                out_data_q <= head_data;
                out_ctrl_q <= head_ctrl;
            end
            if (pkt_done) begin
                pkt_count_q <= pkt_count_q + 32'd1;
            end
            if (drop) begin
                drop_count_q <= drop_count_q + 32'd1;
            end
        end
    end

    assign bus.fifo_rd_en = pop;
    assign bus.out_data   = out_data_q;
    assign bus.out_ctrl   = out_ctrl_q;
    assign bus.out_wr     = out_wr_q;
    assign pkt_count      = pkt_count_q;
    assign drop_count     = drop_count_q;

`ifndef SYNTHESIS
    pop_while_empty: assert property (@(posedge clk) disable iff (reset)
        !(bus.fifo_rd_en && bus.fifo_empty))
        else $error("fifo_pkt_reader: pop while fifo_empty");
`endif

endmodule

// File: tb/tb_fifo_pkt_reader.sv
// Directed bench for fifo_pkt_reader: per-cycle vector table plus counter-wrap sequences.
module tb_fifo_pkt_reader;

    typedef struct {
        logic        rst;
        logic        empty;
        logic [7:0]  ctrl;
        logic [63:0] data;
        logic        rdy;
        logic        en;
        logic        exp_rd;
        logic        exp_wr;
        logic [7:0]  exp_ctrl;
        logic [63:0] exp_data;
        logic [31:0] exp_pkt;
        logic [31:0] exp_drop;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [31:0] pkt_count;
    logic [31:0] drop_count;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t vq[$];

    fifo_pkt_reader_if #(.DATA_WIDTH(64), .CTRL_WIDTH(8)) bus ();

    fifo_pkt_reader #(
        .DATA_WIDTH(64),
        .CTRL_WIDTH(8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .enable     (enable),
        .pkt_count  (pkt_count),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic rst, input logic empty, input logic [7:0] ctrl,
                                input logic [63:0] data, input logic rdy, input logic en,
                                input logic exp_rd, input logic exp_wr,
                                input logic [7:0] exp_ctrl, input logic [63:0] exp_data,
                                input logic [31:0] exp_pkt, input logic [31:0] exp_drop);
        vec_t v;
        v.rst = rst;       v.empty = empty;       v.ctrl = ctrl;         v.data = data;
        v.rdy = rdy;       v.en = en;             v.exp_rd = exp_rd;     v.exp_wr = exp_wr;
        v.exp_ctrl = exp_ctrl; v.exp_data = exp_data;
        v.exp_pkt = exp_pkt;   v.exp_drop = exp_drop;
        vq.push_back(v);
    endfunction

    // Drive just after a falling edge, check rd_en combinationally, then check the
    // registered result of this cycle one full clock later.
    task automatic apply(input vec_t v, input string tag);
        reset          = v.rst;
        bus.fifo_empty = v.empty;
        bus.fifo_dout  = {v.ctrl, v.data};
        bus.out_rdy    = v.rdy;
        enable         = v.en;
        #1;
        chk({tag, " fifo_rd_en"}, 64'(bus.fifo_rd_en), 64'(v.exp_rd));
        @(posedge clk);
        @(negedge clk);
        chk({tag, " out_wr"}, 64'(bus.out_wr), 64'(v.exp_wr));
        chk({tag, " out_ctrl"}, 64'(bus.out_ctrl), 64'(v.exp_ctrl));
        chk({tag, " out_data"}, bus.out_data, v.exp_data);
        chk({tag, " pkt_count"}, 64'(pkt_count), 64'(v.exp_pkt));
        chk({tag, " drop_count"}, 64'(drop_count), 64'(v.exp_drop));
    endtask

    initial begin
        vec_t h;
        reset = 1'b1; enable = 1'b0;
        bus.fifo_empty = 1'b1; bus.fifo_dout = '0; bus.out_rdy = 1'b0;

        //  rst emp ctrl   data      rdy en | rd wr ectrl  edata    pkt drop
        add(1, 1, 8'h00, 64'h0,    1, 1,   0, 0, 8'h00, 64'h0,    0, 0);
        add(1, 0, 8'hFF, 64'h1111, 1, 1,   0, 0, 8'h00, 64'h0,    0, 0);
        add(0, 1, 8'hFF, 64'h1111, 1, 1,   0, 0, 8'h00, 64'h0,    0, 0);
        // Four-word packet, back-to-back
        add(0, 0, 8'hFF, 64'h1111, 1, 1,   1, 1, 8'hFF, 64'h1111, 0, 0);
        add(0, 0, 8'h00, 64'h2222, 1, 1,   1, 1, 8'h00, 64'h2222, 0, 0);
        add(0, 0, 8'h00, 64'h3333, 1, 1,   1, 1, 8'h00, 64'h3333, 0, 0);
        add(0, 0, 8'h01, 64'h4444, 1, 1,   1, 1, 8'h01, 64'h4444, 1, 0);
        // Orphan body word dropped, then enable gating in idle
        add(0, 0, 8'h00, 64'h5555, 1, 1,   1, 0, 8'h01, 64'h4444, 1, 1);
        add(0, 0, 8'h80, 64'h6666, 1, 0,   0, 0, 8'h01, 64'h4444, 1, 1);
        add(0, 0, 8'h80, 64'h6666, 1, 1,   1, 1, 8'h80, 64'h6666, 1, 1);
        add(0, 0, 8'h02, 64'h7777, 1, 1,   1, 1, 8'h02, 64'h7777, 1, 1);
        add(0, 0, 8'h00, 64'h8888, 1, 1,   1, 1, 8'h00, 64'h8888, 1, 1);
        // out_rdy low for three cycles mid-body
        add(0, 0, 8'h00, 64'h9999, 0, 1,   0, 0, 8'h00, 64'h8888, 1, 1);
        add(0, 0, 8'h00, 64'h9999, 0, 1,   0, 0, 8'h00, 64'h8888, 1, 1);
        add(0, 0, 8'h00, 64'h9999, 0, 1,   0, 0, 8'h00, 64'h8888, 1, 1);
        add(0, 0, 8'h00, 64'h9999, 1, 1,   1, 1, 8'h00, 64'h9999, 1, 1);
        // enable dropped mid-packet: packet drains, next one waits
        add(0, 0, 8'h00, 64'hAAAA, 1, 0,   1, 1, 8'h00, 64'hAAAA, 1, 1);
        add(0, 1, 8'h00, 64'hAAAA, 1, 0,   0, 0, 8'h00, 64'hAAAA, 1, 1);
        add(0, 0, 8'h04, 64'hBBBB, 1, 0,   1, 1, 8'h04, 64'hBBBB, 2, 1);
        add(0, 0, 8'h10, 64'hCCCC, 1, 0,   0, 0, 8'h04, 64'hBBBB, 2, 1);
        add(0, 0, 8'h10, 64'hCCCC, 1, 0,   0, 0, 8'h04, 64'hBBBB, 2, 1);
        add(0, 0, 8'h10, 64'hCCCC, 1, 1,   1, 1, 8'h10, 64'hCCCC, 2, 1);
        add(0, 0, 8'h00, 64'hDDDD, 1, 1,   1, 1, 8'h00, 64'hDDDD, 2, 1);
        // Reset in BODY, leftovers dropped as orphans
        add(1, 0, 8'h00, 64'hEEEE, 1, 1,   0, 0, 8'h00, 64'h0,    0, 0);
        add(0, 0, 8'h00, 64'hEEEE, 1, 1,   1, 0, 8'h00, 64'h0,    0, 1);
        add(0, 0, 8'h00, 64'hFFFF, 1, 1,   1, 0, 8'h00, 64'h0,    0, 2);
        add(0, 0, 8'h01, 64'h1234, 1, 1,   1, 1, 8'h01, 64'h1234, 0, 2);
        add(0, 1, 8'h00, 64'h0,    1, 1,   0, 0, 8'h01, 64'h1234, 0, 2);

        foreach (vq[i]) apply(vq[i], $sformatf("vec%0d", i));

        // Counter wrap: preload both counters at all-ones
        vq.delete();
        add(1, 1, 8'h00, 64'h0,    1, 1,   0, 0, 8'h00, 64'h0,    0, 0);
        apply(vq[0], "wrap_reset");
        force dut.pkt_count_q = 32'hFFFF_FFFF;
        #1 release dut.pkt_count_q;
        vq.delete();
        add(0, 0, 8'hFF, 64'hA1,   1, 1,   1, 1, 8'hFF, 64'hA1, 32'hFFFF_FFFF, 0);
        add(0, 0, 8'h00, 64'hA2,   1, 1,   1, 1, 8'h00, 64'hA2, 32'hFFFF_FFFF, 0);
        add(0, 0, 8'h01, 64'hA3,   1, 1,   1, 1, 8'h01, 64'hA3, 0, 0);
        foreach (vq[i]) apply(vq[i], $sformatf("pkt_wrap%0d", i));
        force dut.drop_count_q = 32'hFFFF_FFFF;
        #1 release dut.drop_count_q;
        h.rst = 0;  h.empty = 0; h.ctrl = 8'h00; h.data = 64'hB1; h.rdy = 1; h.en = 1;
        h.exp_rd = 1; h.exp_wr = 0; h.exp_ctrl = 8'h01; h.exp_data = 64'hA3;
        h.exp_pkt = 0; h.exp_drop = 0;
        apply(h, "drop_wrap");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
